// File: rtl/psdsqrt_param_if.sv
// Request/result bundle of the parametrised sequential square-root unit.
// The controller drives start/x/round; the unit returns busy/done and the registered result.
interface psdsqrt_param_if #(
   parameter int NBITS = 32
);
   logic               start;
   logic [NBITS-1:0]   x;
   logic               round;
   logic               busy;
   logic               done;
   logic [NBITS/2-1:0] sqrt;
   logic [NBITS/2:0]   rem;
   logic               sat;

   modport master (
      output start, x, round,
      input  busy, done, sqrt, rem, sat
   );

   modport slave (
      input  start, x, round,
      output busy, done, sqrt, rem, sat
   );
endinterface

// File: rtl/psdsqrt_param.sv
// Sequential integer square root, one result bit per clock, MSB-first trial bits,
// with floor remainder, optional round-to-nearest and a saturation flag.
module psdsqrt_param #(
   parameter int NBITS = 32
) (
   input logic           clock,
   input logic           reset,
   psdsqrt_param_if.slave bus
);
   localparam int HALF = NBITS / 2;
   localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LASTBIT = CW'(HALF - 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t            state;
   state_t            nextState;
   logic [NBITS-1:0]  xLatch;
   logic              roundLatch;
   logic [HALF-1:0]   root;
   logic [HALF-1:0]   mask;
   logic [CW-1:0]     bitCount;
   logic [HALF-1:0]   sqrtReg;
   logic [HALF:0]     remReg;
   logic              satReg;
   logic              doneReg;
   logic [HALF-1:0]   trial;
   logic [NBITS-1:0]  trialSq;
   logic [NBITS-1:0]  rootSq;
   logic [NBITS-1:0]  remFull;

   // Full-width squares: (2^HALF-1)^2 always fits in NBITS bits, so nothing is truncated.
   assign trial   = root | mask;
   assign trialSq = {{HALF{1'b0}}, trial} * {{HALF{1'b0}}, trial};
   assign rootSq  = {{HALF{1'b0}}, root} * {{HALF{1'b0}}, root};
   assign remFull = xLatch - rootSq;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.start) nextState = CALC;
         CALC:    if (bitCount == LASTBIT) nextState = FINISH;
         FINISH:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath: operands are only sampled in IDLE, so start/x/round are ignored while busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xLatch     <= '0;
         roundLatch <= 1'b0;
         root       <= '0;
         mask       <= '0;
         bitCount   <= '0;
         sqrtReg    <= '0;
         remReg     <= '0;
         satReg     <= 1'b0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  xLatch     <= bus.x;
                  roundLatch <= bus.round;
                  root       <= '0;
                  mask       <= {1'b1, {(HALF-1){1'b0}}};
                  bitCount   <= '0;
               end
            end
            CALC: begin
               if (trialSq <= xLatch) begin
                  root <= trial;
               end
               mask     <= mask >> 1;
               bitCount <= bitCount + CW'(1);
            end
            FINISH: begin
               // rem <= 2*root, so the low HALF+1 bits hold it exactly.
               remReg  <= remFull[HALF:0];
               doneReg <= 1'b1;
               if (roundLatch && (remFull > {{HALF{1'b0}}, root})) begin
                  if (&root) begin
                     sqrtReg <= root;
                     satReg  <= 1'b1;
                  end else begin
                     sqrtReg <= root + HALF'(1);
                     satReg  <= 1'b0;
                  end
               end else begin
                  sqrtReg <= root;
                  satReg  <= 1'b0;
               end
            end
            default: begin
               doneReg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = doneReg;
   assign bus.sqrt = sqrtReg;
   assign bus.rem  = remReg;
   assign bus.sat  = satReg;
endmodule

// File: doc/psdsqrt_param.md
Name: psdsqrt_param

Overview:
Parametrised successor of the 32-bit sequential square-root unit. It computes the integer square root of an NBITS-wide unsigned operand with one result bit per clock, using the same MSB-first trial-bit algorithm. It adds four things the fixed unit lacks:
- a self-timed busy/done handshake instead of an external stop strobe;
- a remainder output;
- optional round-to-nearest;
- a saturation flag.

It sits in the datapath as a multi-cycle arithmetic slave driven by a sequential controller.

Parameters:
NBITS  32  operand width; must be even and >= 4; result width is NBITS/2

Ports:
clock  input  1  master clock, active on the positive edge
reset  input  1  master reset, asynchronous, active high
start  input  1  one-cycle request; sampled only while busy=0
x  input  NBITS  unsigned operand; sampled on the edge that accepts start
round  input  1  mode, sampled with start: 0 = floor, 1 = round-to-nearest
busy  output  1  high while a computation is in progress
done  output  1  one-cycle pulse; sqrt, rem and sat are valid from this cycle
sqrt  output  NBITS/2  result register; holds until the next done
rem  output  NBITS/2+1  x - floor_sqrt(x)^2; always the floor remainder, independent of round
sat  output  1  rounding would have exceeded 2^(NBITS/2)-1; held with sqrt

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sqrt=0, rem=0, sat=0.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, CALC, FINISH. busy = (state != IDLE), decoded from registered state.
- IDLE:
  - start=1 at edge E0: latch x and round; root=0; mask=MSB of the NBITS/2 result; bit counter=0; go to CALC.
  - start=0: stay in IDLE; outputs hold.
- CALC: one edge per result bit, N/2 edges in total (E1..E(N/2)):
  - if (root|mask)^2 <= x_latched then root = root|mask;
  - mask >>= 1.
  - After the bit-0 decision (edge E(N/2)), go to FINISH.
- FINISH, at edge E(N/2+1):
  - rem = x - root^2.
  - If round=1 and rem > root:
    - root = 2^(N/2)-1: sqrt=2^(N/2)-1, sat=1.
    - otherwise: sqrt=root+1, sat=0.
  - Else: sqrt=root, sat=0.
  - done=1; go to IDLE.
- Latency: done is high in the cycle immediately after edge E(N/2+1), i.e. N/2+1 edges after the accepting edge (17 for NBITS=32). busy is high for exactly N/2+1 cycles and is already low in the done cycle.
- Bit-exactness: with round=0, sqrt must equal the golden floor-sqrt function bit for bit.
- Rounding rule: x > r^2 + r is equivalent to x >= (r+0.5)^2 for integer x. Ties cannot occur.
- Widths:
  - The trial square fits in NBITS bits because (2^(N/2)-1)^2 < 2^NBITS.
  - rem <= 2*root, so it needs N/2+1 bits.
  - No intermediate truncation is allowed.
  - Implementation may use a multiplier or a restoring shift/subtract datapath, provided the results are identical.
- start while busy=1 is ignored entirely, including changes on x and round.
- start in the done cycle: accepted (state is IDLE); done is still a single pulse.
- x and round may change freely after the accepting edge.
- done never lasts more than one cycle.
- sqrt, rem and sat change only at a FINISH edge or on reset.

Test Plan:
1. NBITS=32, reset pulse misaligned with clock, then x=123456, round=0 → done exactly 17 cycles after start; sqrt=351, rem=255, sat=0; busy high for 17 cycles.
2. Rounding boundary, round=1:
   - x=123552 → sqrt=351, rem=351.
   - x=123553 → sqrt=352, rem=352.
   - x=0 → sqrt=0, rem=0.
3. Saturation: x=32'hFFFF_FFFF.
   - round=0 → sqrt=65535, rem=131070, sat=0.
   - round=1 → sqrt=65535, sat=1.
4. Handshake:
   - start pulsed and x changed mid-CALC → ignored; result matches the first operand.
   - start held in the done cycle → second operation accepted; second done 17 cycles later.
5. Reset asserted asynchronously 8 cycles into CALC → busy, done, sqrt, rem and sat go to 0 immediately, with no later done pulse. The next start then computes correctly.
6. NBITS=16 instance:
   - x=65535 → sqrt=255, rem=510, latency 9 cycles.
   - Random sweep checked against the golden floor function with round=0, and against the rounding rule with round=1.
